// File: rtl/fanout_bcast_sched_if.sv
// Requester-side and tree-side signal bundle for fanout_bcast_sched.
// master = producers plus tree/downstream environment, slave = the scheduler.
interface fanout_bcast_sched_if #(
  parameter int NUM_REQ = 3,
  parameter int DAT_W   = 1024,
  parameter int SRC_W   = 2
);
  logic [NUM_REQ-1:0]       req_vld;
  logic [NUM_REQ*DAT_W-1:0] req_dat;
  logic [NUM_REQ-1:0]       req_last;
  logic [NUM_REQ-1:0]       req_rdy;
  logic                     tree_vld;
  logic [DAT_W-1:0]         tree_dat;
  logic                     tree_dn_vld;
  logic                     out_vld;
  logic [SRC_W-1:0]         out_src;
  logic                     out_last;
  logic                     crd_rtn;

  modport master (
    output req_vld, req_dat, req_last, tree_dn_vld, crd_rtn,
    input  req_rdy, tree_vld, tree_dat, out_vld, out_src, out_last
  );

  modport slave (
    input  req_vld, req_dat, req_last, tree_dn_vld, crd_rtn,
    output req_rdy, tree_vld, tree_dat, out_vld, out_src, out_last
  );
endinterface

// File: rtl/fanout_bcast_sched.sv
// Round-robin, credit-gated packet scheduler for a shared fixed-latency broadcast tree.
// Optional: define FANOUT_SCHED_ALIGN_CHK_EN to flag tree_dn_vld / tag-pipe misalignment in err.
module fanout_bcast_sched #(
  parameter int NUM_REQ  = 3,
  parameter int DAT_W    = 1024,
  parameter int TREE_LAT = 4,
  parameter int CREDITS  = 8,
  parameter int SRC_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_en,
  fanout_bcast_sched_if.slave  bus,
  output logic                 busy,
  output logic                 err
);
  localparam int CRD_W = $clog2(CREDITS + 1);
  localparam logic [CRD_W-1:0] CRD_MAX   = CRD_W'(CREDITS);
  localparam logic [SRC_W:0]   NUM_REQ_L = (SRC_W + 1)'(NUM_REQ);
  localparam logic [SRC_W-1:0] LAST_IDX  = SRC_W'(NUM_REQ - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state_reg, state_next;
  logic [SRC_W-1:0]      owner_reg, owner_next;
  logic [SRC_W-1:0]      ptr_reg, ptr_next;
  logic [CRD_W-1:0]      credit_reg, credit_next;
  logic                  err_reg;
  logic [DAT_W-1:0]      tree_dat_reg;
  logic [TREE_LAT:0]     tag_vld_reg;
  logic [SRC_W-1:0]      tag_src_reg  [TREE_LAT+1];
  logic [TREE_LAT:0]     tag_last_reg;

  logic                  has_credit;
  logic [2*NUM_REQ-1:0]  vld_dbl;
  logic [NUM_REQ-1:0]    vld_rot;
  logic                  grant_found;
  logic [SRC_W-1:0]      grant_off;
  logic [SRC_W:0]        grant_sum;
  logic [SRC_W-1:0]      grant_idx;
  logic [NUM_REQ-1:0]    rdy_vec;
  logic [NUM_REQ-1:0]    issue_vec;
  logic                  issue;
  logic                  issue_last;
  logic [SRC_W-1:0]      acc_src;
  logic [SRC_W-1:0]      acc_src_inc;
  logic [DAT_W-1:0]      dat_masked [NUM_REQ];
  logic [DAT_W-1:0]      dat_sel;
  logic                  crd_ovf;
  logic                  align_err;

  assign has_credit = (credit_reg != '0);

  // Rotate valids so bit 0 is the requester at the RR pointer; first set bit wins.
  always_comb begin
    vld_dbl     = {bus.req_vld, bus.req_vld} >> ptr_reg;
    vld_rot     = vld_dbl[NUM_REQ-1:0];
    grant_found = 1'b0;
    grant_off   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && vld_rot[k]) begin
        grant_found = 1'b1;
        grant_off   = SRC_W'(k);
      end
    end
    grant_sum = {1'b0, ptr_reg} + {1'b0, grant_off};
    if (grant_sum >= NUM_REQ_L) begin
      grant_sum = grant_sum - NUM_REQ_L;
    end
    grant_idx = grant_sum[SRC_W-1:0];
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    localparam logic [SRC_W-1:0] GI = SRC_W'(gi);
    assign rdy_vec[gi] = rst_n && has_credit &&
                         (((state_reg == IDLE) && cfg_en && grant_found && (grant_idx == GI)) ||
                          ((state_reg == BURST) && (owner_reg == GI)));
    assign dat_masked[gi] = issue_vec[gi] ? bus.req_dat[gi*DAT_W +: DAT_W] : '0;
  end

  assign bus.req_rdy = rdy_vec;
  assign issue_vec   = bus.req_vld & rdy_vec;
  assign issue       = |issue_vec;
  assign issue_last  = |(issue_vec & bus.req_last);
  assign acc_src     = (state_reg == BURST) ? owner_reg : grant_idx;
  assign acc_src_inc = (acc_src == LAST_IDX) ? '0 : acc_src + SRC_W'(1);

  always_comb begin
    dat_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      dat_sel = dat_sel | dat_masked[i];
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    ptr_next   = ptr_reg;
    if (issue) begin
      if (issue_last) begin
        state_next = IDLE;
        ptr_next   = acc_src_inc;
      end else begin
        state_next = BURST;
        owner_next = acc_src;
      end
    end
  end

  // Same-cycle issue and return cancel; a return with nothing outstanding is an error.
  always_comb begin
    credit_next = credit_reg;
    crd_ovf     = 1'b0;
    case ({issue, bus.crd_rtn})
      2'b10: credit_next = credit_reg - CRD_W'(1);
      2'b01: begin
        if (credit_reg == CRD_MAX) begin
          crd_ovf = 1'b1;
        end else begin
          credit_next = credit_reg + CRD_W'(1);
        end
      end
      default: credit_next = credit_reg;
    endcase
  end

`ifdef FANOUT_SCHED_ALIGN_CHK_EN
  assign align_err = (bus.tree_dn_vld != tag_vld_reg[TREE_LAT]);
`else
  logic unused_tree_dn_vld;
  assign unused_tree_dn_vld = bus.tree_dn_vld;
  assign align_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      owner_reg    <= '0;
      ptr_reg      <= '0;
      credit_reg   <= CRD_MAX;
      err_reg      <= 1'b0;
      tree_dat_reg <= '0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      ptr_reg    <= ptr_next;
      credit_reg <= credit_next;
      err_reg    <= err_reg | crd_ovf | align_err;
      if (issue) begin
        tree_dat_reg <= dat_sel;
      end
    end
  end

  // Stage 0 doubles as tree_vld; stage TREE_LAT lines up with the tree output beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_reg  <= '0;
      tag_last_reg <= '0;
      for (int s = 0; s <= TREE_LAT; s++) begin
        tag_src_reg[s] <= '0;
      end
    end else begin
      tag_vld_reg[0]  <= issue;
      tag_last_reg[0] <= issue_last;
      tag_src_reg[0]  <= issue ? acc_src : '0;
      for (int s = 1; s <= TREE_LAT; s++) begin
        tag_vld_reg[s]  <= tag_vld_reg[s-1];
        tag_last_reg[s] <= tag_last_reg[s-1];
        tag_src_reg[s]  <= tag_src_reg[s-1];
      end
    end
  end

  assign bus.tree_vld = tag_vld_reg[0];
  assign bus.tree_dat = tree_dat_reg;
  assign bus.out_vld  = tag_vld_reg[TREE_LAT];
  assign bus.out_src  = tag_src_reg[TREE_LAT];
  assign bus.out_last = tag_last_reg[TREE_LAT];
  assign busy         = (state_reg == BURST) | (|tag_vld_reg);
  assign err          = err_reg;
endmodule

// File: tb/tb_fanout_bcast_sched.sv
module tb_fanout_bcast_sched;
    localparam int NUM_REQ  = 3;
    localparam int DAT_W    = 16;
    localparam int TREE_LAT = 4;
    localparam int CREDITS  = 8;
    localparam int SRC_W    = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic cfg_en;
    logic busy;
    logic err;
    int   checks = 0;
    int   errors = 0;
    logic [2:0]  exp_rdy;
    logic [15:0] exp_dat;
    logic [TREE_LAT-1:0] dn_sh;

    fanout_bcast_sched_if #(.NUM_REQ(NUM_REQ), .DAT_W(DAT_W), .SRC_W(SRC_W)) bus ();

    fanout_bcast_sched #(
        .NUM_REQ (NUM_REQ),
        .DAT_W   (DAT_W),
        .TREE_LAT(TREE_LAT),
        .CREDITS (CREDITS),
        .SRC_W   (SRC_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cfg_en(cfg_en),
        .bus   (bus.slave),
        .busy  (busy),
        .err   (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) dn_sh <= '0;
        else        dn_sh <= {dn_sh[TREE_LAT-2:0], bus.tree_vld};
    end
    assign bus.tree_dn_vld = dn_sh[TREE_LAT-1];

    always @(negedge clk) begin
        if (bus.out_vld) $display("beat out src=%0d last=%0d", bus.out_src, bus.out_last);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dat(input int i, input logic [15:0] d);
        bus.req_dat[i*DAT_W +: DAT_W] = d;
    endtask

    task automatic fail(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        errors++;
        $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; cfg_en = 1'b0;
        bus.req_vld = '0; bus.req_dat = '0; bus.req_last = '0; bus.crd_rtn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.req_rdy !== 3'b000) fail("rst_rdy", bus.req_rdy, 3'b000);
        checks++; if (bus.tree_vld !== 1'b0) fail("rst_tree_vld", bus.tree_vld, 1'b0);
        checks++; if (bus.tree_dat !== 16'h0000) fail("rst_tree_dat", bus.tree_dat, 16'h0000);
        checks++; if (bus.out_vld !== 1'b0) fail("rst_out_vld", bus.out_vld, 1'b0);
        checks++; if (bus.out_src !== 2'd0) fail("rst_out_src", bus.out_src, 2'd0);
        checks++; if (bus.out_last !== 1'b0) fail("rst_out_last", bus.out_last, 1'b0);
        checks++; if (busy !== 1'b0) fail("rst_busy", busy, 1'b0);
        checks++; if (err !== 1'b0) fail("rst_err", err, 1'b0);
        checks++; if (dut.credit_reg !== 4'd8) fail("rst_credit", dut.credit_reg, 4'd8);
        rst_n = 1'b1; cfg_en = 1'b1;
        tick();

        bus.req_vld = 3'b010; set_dat(1, 16'h000A); #1;
        checks++; if (bus.req_rdy !== 3'b010) fail("sp_rdy0", bus.req_rdy, 3'b010);
        tick();
        checks++; if (bus.tree_vld !== 1'b1) fail("sp_tvld1", bus.tree_vld, 1'b1);
        checks++; if (bus.tree_dat !== 16'h000A) fail("sp_tdat1", bus.tree_dat, 16'h000A);
        set_dat(1, 16'h000B); #1;
        checks++; if (bus.req_rdy !== 3'b010) fail("sp_rdy1", bus.req_rdy, 3'b010);
        tick();
        checks++; if (bus.tree_dat !== 16'h000B) fail("sp_tdat2", bus.tree_dat, 16'h000B);
        set_dat(1, 16'h000C); bus.req_last = 3'b010;
        tick();
        checks++; if (bus.tree_vld !== 1'b1) fail("sp_tvld3", bus.tree_vld, 1'b1);
        checks++; if (bus.tree_dat !== 16'h000C) fail("sp_tdat3", bus.tree_dat, 16'h000C);
        bus.req_vld = '0; bus.req_last = '0; #1;
        checks++; if (bus.req_rdy !== 3'b000) fail("sp_rdy_idle", bus.req_rdy, 3'b000);
        checks++; if (dut.credit_reg !== 4'd5) fail("sp_credit", dut.credit_reg, 4'd5);
        checks++; if (busy !== 1'b1) fail("sp_busy", busy, 1'b1);
        tick();
        checks++; if (bus.tree_vld !== 1'b0) fail("sp_tvld4", bus.tree_vld, 1'b0);
        checks++; if (bus.tree_dat !== 16'h000C) fail("sp_tdat_hold", bus.tree_dat, 16'h000C);
        checks++; if (bus.out_vld !== 1'b0) fail("sp_ovld4", bus.out_vld, 1'b0);
        tick();
        checks++; if (bus.out_vld !== 1'b1) fail("sp_ovld5", bus.out_vld, 1'b1);
        checks++; if (bus.out_src !== 2'd1) fail("sp_osrc5", bus.out_src, 2'd1);
        checks++; if (bus.out_last !== 1'b0) fail("sp_olast5", bus.out_last, 1'b0);
        tick();
        checks++; if (bus.out_vld !== 1'b1) fail("sp_ovld6", bus.out_vld, 1'b1);
        checks++; if (bus.out_last !== 1'b0) fail("sp_olast6", bus.out_last, 1'b0);
        tick();
        checks++; if (bus.out_vld !== 1'b1) fail("sp_ovld7", bus.out_vld, 1'b1);
        checks++; if (bus.out_src !== 2'd1) fail("sp_osrc7", bus.out_src, 2'd1);
        checks++; if (bus.out_last !== 1'b1) fail("sp_olast7", bus.out_last, 1'b1);
        tick();
        checks++; if (bus.out_vld !== 1'b0) fail("sp_ovld8", bus.out_vld, 1'b0);
        checks++; if (busy !== 1'b0) fail("sp_busy8", busy, 1'b0);
        bus.crd_rtn = 1'b1;
        repeat (3) tick();
        bus.crd_rtn = 1'b0;
        checks++; if (dut.credit_reg !== 4'd8) fail("sp_credit_back", dut.credit_reg, 4'd8);
        checks++; if (err !== 1'b0) fail("sp_err", err, 1'b0);

        bus.req_vld = 3'b100; bus.req_last = 3'b100; set_dat(2, 16'h0102); #1;
        checks++; if (bus.req_rdy !== 3'b100) fail("rr_pre_rdy", bus.req_rdy, 3'b100);
        tick();
        bus.req_vld = 3'b111; bus.req_last = 3'b111;
        set_dat(0, 16'h0100); set_dat(1, 16'h0101); set_dat(2, 16'h0102);
        bus.crd_rtn = 1'b1;
        for (int n = 0; n < 6; n++) begin
            exp_rdy = 3'(1 << (n % 3));
            exp_dat = 16'h0100 + 16'(n % 3);
            #1;
            checks++; if (bus.req_rdy !== exp_rdy) fail("rr_rdy", bus.req_rdy, exp_rdy);
            tick();
            checks++; if (bus.tree_vld !== 1'b1) fail("rr_tvld", bus.tree_vld, 1'b1);
            checks++; if (bus.tree_dat !== exp_dat) fail("rr_tdat", bus.tree_dat, exp_dat);
        end
        bus.req_vld = '0; bus.req_last = '0;
        tick();
        bus.crd_rtn = 1'b0;
        checks++; if (dut.credit_reg !== 4'd8) fail("rr_credit", dut.credit_reg, 4'd8);
        checks++; if (err !== 1'b0) fail("rr_err", err, 1'b0);

        bus.req_vld = 3'b101; set_dat(2, 16'h02C2);
        for (int b = 0; b < 4; b++) begin
            bus.req_last = (b == 3) ? 3'b101 : 3'b100;
            set_dat(0, 16'h00B0 + 16'(b));
            exp_dat = 16'h00B0 + 16'(b);
            #1;
            checks++; if (bus.req_rdy !== 3'b001) fail("bl_rdy", bus.req_rdy, 3'b001);
            tick();
            checks++; if (bus.tree_dat !== exp_dat) fail("bl_tdat", bus.tree_dat, exp_dat);
        end
        bus.req_vld = 3'b100; #1;
        checks++; if (bus.req_rdy !== 3'b100) fail("bl_rdy2", bus.req_rdy, 3'b100);
        tick();
        checks++; if (bus.tree_dat !== 16'h02C2) fail("bl_tdat2", bus.tree_dat, 16'h02C2);
        checks++; if (dut.credit_reg !== 4'd3) fail("bl_credit", dut.credit_reg, 4'd3);
        bus.req_vld = '0; bus.req_last = '0;
        bus.crd_rtn = 1'b1;
        repeat (5) tick();
        bus.crd_rtn = 1'b0;

        bus.req_vld = 3'b010; bus.req_last = 3'b010; set_dat(1, 16'h00D1);
        for (int n = 0; n < 8; n++) begin
            #1;
            checks++; if (bus.req_rdy !== 3'b010) fail("ce_rdy", bus.req_rdy, 3'b010);
            tick();
        end
        #1;
        checks++; if (bus.req_rdy !== 3'b000) fail("ce_rdy_empty", bus.req_rdy, 3'b000);
        checks++; if (dut.credit_reg !== 4'd0) fail("ce_credit0", dut.credit_reg, 4'd0);
        bus.crd_rtn = 1'b1; #1;
        checks++; if (bus.req_rdy !== 3'b000) fail("ce_no_bypass", bus.req_rdy, 3'b000);
        tick();
        bus.crd_rtn = 1'b0;
        checks++; if (bus.tree_vld !== 1'b0) fail("ce_tvld_gap", bus.tree_vld, 1'b0);
        checks++; if (dut.credit_reg !== 4'd1) fail("ce_credit1", dut.credit_reg, 4'd1);
        #1;
        checks++; if (bus.req_rdy !== 3'b010) fail("ce_rdy_ret", bus.req_rdy, 3'b010);
        bus.crd_rtn = 1'b1;
        tick();
        bus.crd_rtn = 1'b0;
        checks++; if (dut.credit_reg !== 4'd1) fail("sim_credit", dut.credit_reg, 4'd1);
        checks++; if (bus.tree_vld !== 1'b1) fail("sim_tvld", bus.tree_vld, 1'b1);
        #1;
        checks++; if (bus.req_rdy !== 3'b010) fail("sim_rdy", bus.req_rdy, 3'b010);
        tick();
        checks++; if (dut.credit_reg !== 4'd0) fail("sim_credit0", dut.credit_reg, 4'd0);
        #1;
        checks++; if (bus.req_rdy !== 3'b000) fail("sim_rdy_empty", bus.req_rdy, 3'b000);
        bus.req_vld = '0; bus.req_last = '0;
        bus.crd_rtn = 1'b1;
        repeat (8) tick();
        checks++; if (dut.credit_reg !== 4'd8) fail("ovf_credit", dut.credit_reg, 4'd8);
        checks++; if (err !== 1'b0) fail("ovf_err_pre", err, 1'b0);
        tick();
        bus.crd_rtn = 1'b0;
        checks++; if (err !== 1'b1) fail("ovf_err", err, 1'b1);
        checks++; if (dut.credit_reg !== 4'd8) fail("ovf_credit_hold", dut.credit_reg, 4'd8);
        tick();
        checks++; if (err !== 1'b1) fail("ovf_err_sticky", err, 1'b1);

        bus.req_vld = 3'b001; set_dat(0, 16'h00E0); #1;
        checks++; if (bus.req_rdy !== 3'b001) fail("rb_rdy", bus.req_rdy, 3'b001);
        tick();
        tick();
        checks++; if (busy !== 1'b1) fail("rb_busy", busy, 1'b1);
        checks++; if (bus.tree_vld !== 1'b1) fail("rb_tvld", bus.tree_vld, 1'b1);
        rst_n = 1'b0; bus.req_vld = '0; #1;
        checks++; if (bus.tree_vld !== 1'b0) fail("rb_tvld_rst", bus.tree_vld, 1'b0);
        checks++; if (bus.tree_dat !== 16'h0000) fail("rb_tdat_rst", bus.tree_dat, 16'h0000);
        checks++; if (busy !== 1'b0) fail("rb_busy_rst", busy, 1'b0);
        checks++; if (err !== 1'b0) fail("rb_err_rst", err, 1'b0);
        tick();
        rst_n = 1'b1;
        checks++; if (dut.credit_reg !== 4'd8) fail("rb_credit", dut.credit_reg, 4'd8);
        for (int n = 0; n < 6; n++) begin
            tick();
            checks++; if (bus.out_vld !== 1'b0) fail("rb_ovld", bus.out_vld, 1'b0);
            checks++; if (busy !== 1'b0) fail("rb_busy_post", busy, 1'b0);
        end

        cfg_en = 1'b1; bus.req_vld = 3'b010; bus.req_last = '0; set_dat(1, 16'h00F0); #1;
        checks++; if (bus.req_rdy !== 3'b010) fail("en_rdy0", bus.req_rdy, 3'b010);
        tick();
        cfg_en = 1'b0; set_dat(1, 16'h00F1); #1;
        checks++; if (bus.req_rdy !== 3'b010) fail("en_rdy1", bus.req_rdy, 3'b010);
        tick();
        bus.req_last = 3'b010; set_dat(1, 16'h00F2); #1;
        checks++; if (bus.req_rdy !== 3'b010) fail("en_rdy2", bus.req_rdy, 3'b010);
        tick();
        checks++; if (bus.tree_dat !== 16'h00F2) fail("en_tdat", bus.tree_dat, 16'h00F2);
        bus.req_vld = 3'b111; bus.req_last = 3'b111; #1;
        checks++; if (bus.req_rdy !== 3'b000) fail("en_blocked", bus.req_rdy, 3'b000);
        tick();
        checks++; if (bus.tree_vld !== 1'b0) fail("en_tvld_off", bus.tree_vld, 1'b0);
        #1;
        checks++; if (bus.req_rdy !== 3'b000) fail("en_blocked2", bus.req_rdy, 3'b000);
        bus.req_vld = '0; bus.req_last = '0;
        repeat (8) tick();
        checks++; if (busy !== 1'b0) fail("en_busy_done", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
